// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: run-state encoding.
package timer_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_RUNNING = 1'b1;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter / rate divider: counts a loaded value to zero, pulses Done on
// expiry and optionally reloads for periodic ticks.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Enable,
  input  logic             AutoReload,
  output logic [WIDTH-1:0] CounterValue,
  output logic             Done,
  output logic             Busy
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  state_t           state_q, state_d;
  logic             done_q, done_d;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    state_d  = state_q;
    done_d   = 1'b0;
    if (Load) begin
      count_d  = LoadValue;
      reload_d = LoadValue;
      state_d  = ST_RUNNING;
    end else if (state_q == ST_RUNNING && Enable) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else if (count_q == ONE) begin
        count_d = ZERO;
        done_d  = 1'b1;
        if (!AutoReload) state_d = ST_IDLE;
      end else if (AutoReload) begin
        // Sitting at zero: reload; a zero reload value means divide-by-1.
        count_d = reload_q;
        done_d  = (reload_q == ZERO);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      count_q  <= ZERO;
      reload_q <= ZERO;
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      done_q   <= done_d;
    end
  end

  assign CounterValue = count_q;
  assign Done         = done_q;
  assign Busy         = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, a clear-abort sequence, and
// randomized traffic against a behavioural model.
module tb_countdown_timer;

  logic       Clock = 1'b0;
  logic       Clear = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] LoadValue = '0;
  logic       Enable = 1'b0;
  logic       AutoReload = 1'b0;
  logic [7:0] CounterValue;
  logic       Done;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .Clock(Clock), .Clear(Clear), .Load(Load), .LoadValue(LoadValue),
    .Enable(Enable), .AutoReload(AutoReload),
    .CounterValue(CounterValue), .Done(Done), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit clr; bit ld; int lv; bit en; bit ar;
    int cnt; bit done; bit busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit clr, bit ld, int lv, bit en, bit ar, int cnt, bit done, bit busy);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.ar = ar;
    v.cnt = cnt; v.done = done; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic check(string nm, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(bit clr, bit ld, int lv, bit en, bit ar);
    Clear = clr; Load = ld; LoadValue = 8'(lv); Enable = en; AutoReload = ar;
    @(posedge Clock);
    #1;
  endtask

  // Behavioural reference model state
  int m_cnt, m_rel;
  bit m_run, m_done;

  task automatic model_step(bit clr, bit ld, int lv, bit en, bit ar);
    m_done = 0;
    if (clr) begin
      m_cnt = 0; m_rel = 0; m_run = 0;
    end else if (ld) begin
      m_cnt = lv; m_rel = lv; m_run = 1;
    end else if (m_run && en) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1;
          if (!ar) m_run = 0;
        end
      end else if (ar) begin
        m_cnt  = m_rel;
        m_done = (m_rel == 0);
      end else begin
        m_run = 0;
      end
    end
  endtask

  initial begin
    // Reset held two cycles with Enable high, then idle hold
    add(1,0,0,1,0, 0,0,0);
    add(1,0,0,1,0, 0,0,0);
    add(0,0,0,1,0, 0,0,0);
    add(0,0,0,1,1, 0,0,0);
    // One-shot R=3
    add(0,1,3,1,0, 3,0,1);
    add(0,0,0,1,0, 2,0,1);
    add(0,0,0,1,0, 1,0,1);
    add(0,0,0,1,0, 0,1,0);
    add(0,0,0,1,0, 0,0,0);
    add(0,0,0,1,0, 0,0,0);
    // Periodic R=4: Done on cycles 4, 9, 14 after Load
    add(0,1,4,1,1, 4,0,1);
    for (int c = 1; c <= 15; c++)
      add(0,0,0,1,1, (4 - ((c - 1) % 5 + 1) + 5) % 5, (c % 5) == 4, 1);
    // Divide-by-1, then switch to one-shot
    add(0,1,0,1,1, 0,0,1);
    add(0,0,0,1,1, 0,1,1);
    add(0,0,0,1,1, 0,1,1);
    add(0,0,0,1,1, 0,1,1);
    add(0,0,0,1,0, 0,0,0);
    add(0,0,0,1,0, 0,0,0);
    // Enable gating with R=5
    add(0,1,5,1,0, 5,0,1);
    add(0,0,0,1,0, 4,0,1);
    add(0,0,0,0,0, 4,0,1);
    add(0,0,0,0,0, 4,0,1);
    add(0,0,0,1,0, 3,0,1);
    add(0,0,0,1,0, 2,0,1);
    // Clear beats Load
    add(0,1,6,1,0, 6,0,1);
    add(0,0,0,1,0, 5,0,1);
    add(0,0,0,1,0, 4,0,1);
    add(1,1,2,1,0, 0,0,0);
    add(0,0,0,1,0, 0,0,0);
    // Load restarts a running count
    add(0,1,6,1,0, 6,0,1);
    add(0,0,0,1,0, 5,0,1);
    add(0,0,0,1,0, 4,0,1);
    add(0,1,2,1,0, 2,0,1);
    add(0,0,0,1,0, 1,0,1);
    add(0,0,0,1,0, 0,1,0);
    // Maximum value loads without wrap issues; one-shot zero load
    add(0,1,255,1,0, 255,0,1);
    add(0,0,0,1,0, 254,0,1);
    add(0,1,0,1,0, 0,0,1);
    add(0,0,0,1,0, 0,0,0);
    add(0,0,0,1,1, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar);
      check("vec_count", i, int'(CounterValue), vecs[i].cnt);
      check("vec_done",  i, int'(Done), int'(vecs[i].done));
      check("vec_busy",  i, int'(Busy), int'(vecs[i].busy));
    end

    // Clear mid-run: abort with no Done even where expiry would have fallen
    drive(0,1,2,1,0);
    drive(0,0,0,1,0);
    drive(1,0,0,1,0);
    for (int i = 0; i < 4; i++) begin
      check("abort_done", i, int'(Done), 0);
      check("abort_busy", i, int'(Busy), 0);
      check("abort_count", i, int'(CounterValue), 0);
      drive(0,0,0,1,0);
    end

    // Randomized traffic against the model
    m_cnt = 0; m_rel = 0; m_run = 0; m_done = 0;
    drive(1,0,0,0,0);
    model_step(1,0,0,0,0);
    begin
      bit ar_r = 0;
      for (int i = 0; i < 3000; i++) begin
        bit clr, ld, en;
        int lv;
        clr = ($urandom_range(0, 99) == 0);
        ld  = ($urandom_range(0, 15) == 0);
        lv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 6));
        en  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) ar_r = ~ar_r;
        drive(clr, ld, lv, en, ar_r);
        model_step(clr, ld, lv, en, ar_r);
        check("rnd_count", i, int'(CounterValue), m_cnt);
        check("rnd_done",  i, int'(Done), int'(m_done));
        check("rnd_busy",  i, int'(Busy), int'(m_run));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
